// File: rtl/button_pkg.sv
// Shared state encoding and 50 MHz default timing for the button classifier.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_DB  = 3'd1,
    PRESSED   = 3'd2,
    LONG_HOLD = 3'd3,
    REL_DB    = 3'd4
  } btn_state_t;

  localparam int DEBOUNCE_10MS = 500_000;
  localparam int LONG_1S       = 50_000_000;
  localparam int REPEAT_250MS  = 12_500_000;

endpackage

// File: rtl/button_channel_fsm.sv
// One button channel: 2-flop synchroniser, press/release debounce, short/long
// classification and auto-repeat, all outputs registered.
//
// state     | meaning
// IDLE      | button released, waiting for synchronised level to go high
// PRESS_DB  | counting stable-high cycles before accepting the press
// PRESSED   | press accepted, timing towards the long-press threshold
// LONG_HOLD | long press reported, generating repeat pulses
// REL_DB    | counting stable-low cycles before accepting the release
module button_channel_fsm
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_10MS,
  parameter int LONG_CYC     = LONG_1S,
  parameter int REPEAT_CYC   = REPEAT_250MS,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic short_o,
  output logic long_o,
  output logic repeat_o,
  output logic held_o
);

  localparam int HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int DB_W     = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYC - 1);

  logic              sync1_q;
  logic              sync2_q;
  btn_state_t        state_q;
  logic [DB_W-1:0]   db_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              was_long_q;
  logic              short_q;
  logic              long_q;
  logic              repeat_q;
  logic              held_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      was_long_q <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_q  <= PRESS_DB;
            db_cnt_q <= '0;
          end
        end
        PRESS_DB: begin
          if (!sync2_q) begin
            state_q <= IDLE;
          end else if (db_cnt_q == DB_LAST) begin
            state_q    <= PRESSED;
            hold_cnt_q <= '0;
            was_long_q <= 1'b0;
            held_q     <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          // Reaching the long threshold takes priority over a release edge.
          if (hold_cnt_q == LONG_LAST) begin
            state_q    <= LONG_HOLD;
            long_q     <= 1'b1;
            hold_cnt_q <= '0;
            was_long_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
            if (!sync2_q) begin
              state_q  <= REL_DB;
              db_cnt_q <= '0;
            end
          end
        end
        LONG_HOLD: begin
          if (REPEAT_EN) begin
            if (hold_cnt_q == REP_LAST) begin
              repeat_q   <= 1'b1;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          if (!sync2_q) begin
            state_q  <= REL_DB;
            db_cnt_q <= '0;
          end
        end
        REL_DB: begin
          // A return to high is a bounce; hold_cnt_q resumes where it stopped.
          if (sync2_q) begin
            state_q <= was_long_q ? LONG_HOLD : PRESSED;
          end else if (db_cnt_q == DB_LAST) begin
            state_q <= IDLE;
            held_q  <= 1'b0;
            short_q <= ~was_long_q;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign short_o  = short_q;
  assign long_o   = long_q;
  assign repeat_o = repeat_q;
  assign held_o   = held_q;

endmodule

// File: rtl/button_press_classifier.sv
// Multi-channel push-button classifier: one independent debounce/classify
// channel per raw button input.
module button_press_classifier
  import button_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DEBOUNCE_CYC = DEBOUNCE_10MS,
  parameter int LONG_CYC     = LONG_1S,
  parameter int REPEAT_CYC   = REPEAT_250MS,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic              CLOCK_50MHz,
  input  logic              RESET_n,
  input  logic [NUM_CH-1:0] B_Trigger,
  output logic [NUM_CH-1:0] B_Short,
  output logic [NUM_CH-1:0] B_Long,
  output logic [NUM_CH-1:0] B_Repeat,
  output logic [NUM_CH-1:0] B_Held
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("NUM_CH must be >= 1");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be >= 1");
  end
  if (LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_long
    $error("LONG_CYC must be greater than DEBOUNCE_CYC");
  end
  if (REPEAT_CYC < 1) begin : g_bad_repeat
    $error("REPEAT_CYC must be >= 1");
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    button_channel_fsm #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC),
      .REPEAT_EN   (REPEAT_EN)
    ) u_fsm (
      .clk_i   (CLOCK_50MHz),
      .rst_n_i (RESET_n),
      .btn_i   (B_Trigger[ch]),
      .short_o (B_Short[ch]),
      .long_o  (B_Long[ch]),
      .repeat_o(B_Repeat[ch]),
      .held_o  (B_Held[ch])
    );
  end

endmodule
